// File: rtl/text_cursor_writer.sv
// Text cursor writer: turns PS/2 Set-2 scan-code bytes into character writes
// for the dual-port text RAM. Tracks the cursor, shift and caps lock, handles
// Enter and Backspace, and sweeps the whole screen blank on request.
module text_cursor_writer #(
   parameter int         COLS       = 80,
   parameter int         ROWS       = 30,
   parameter int         ADDR_W     = 12,
   parameter logic [7:0] BLANK_CHAR = 8'h20
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [7:0]        code,
   input  logic              code_valid,
   input  logic              clear_req,
   output logic              wr_en,
   output logic [ADDR_W-1:0] wr_addr,
   output logic [7:0]        wr_data,
   output logic [6:0]        cur_col,
   output logic [4:0]        cur_row,
   output logic              busy
);

   typedef enum logic [1:0] {IDLE, BRK, EXT, CLEAR} state_t;

   localparam logic [6:0]        LAST_COL  = 7'(COLS - 1);
   localparam logic [4:0]        LAST_ROW  = 5'(ROWS - 1);
   localparam logic [ADDR_W-1:0] ROW_STEP  = ADDR_W'(COLS);
   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(COLS * ROWS - 1);
   localparam logic [ADDR_W-1:0] ONE       = ADDR_W'(1);

   state_t state, next_state;

   logic              shift, caps;
   logic              nxt_shift, nxt_caps;
   logic [ADDR_W-1:0] row_base, nxt_row_base;
   logic              nxt_wr_en;
   logic [ADDR_W-1:0] nxt_wr_addr;
   logic [7:0]        nxt_wr_data;
   logic [6:0]        nxt_col;
   logic [4:0]        nxt_row;
   logic [9:0]        lookup;

   // Translates a make code into {printable, letter, lowercase ASCII}
   function automatic logic [9:0] scan_lookup(input logic [7:0] sc);
      logic [9:0] r;
      case (sc)
         8'h1C: r = {2'b11, 8'h61};
         8'h32: r = {2'b11, 8'h62};
         8'h21: r = {2'b11, 8'h63};
         8'h23: r = {2'b11, 8'h64};
         8'h24: r = {2'b11, 8'h65};
         8'h2B: r = {2'b11, 8'h66};
         8'h34: r = {2'b11, 8'h67};
         8'h33: r = {2'b11, 8'h68};
         8'h43: r = {2'b11, 8'h69};
         8'h3B: r = {2'b11, 8'h6A};
         8'h42: r = {2'b11, 8'h6B};
         8'h4B: r = {2'b11, 8'h6C};
         8'h3A: r = {2'b11, 8'h6D};
         8'h31: r = {2'b11, 8'h6E};
         8'h44: r = {2'b11, 8'h6F};
         8'h4D: r = {2'b11, 8'h70};
         8'h15: r = {2'b11, 8'h71};
         8'h2D: r = {2'b11, 8'h72};
         8'h1B: r = {2'b11, 8'h73};
         8'h2C: r = {2'b11, 8'h74};
         8'h3C: r = {2'b11, 8'h75};
         8'h2A: r = {2'b11, 8'h76};
         8'h1D: r = {2'b11, 8'h77};
         8'h22: r = {2'b11, 8'h78};
         8'h35: r = {2'b11, 8'h79};
         8'h1A: r = {2'b11, 8'h7A};
         8'h45: r = {2'b10, 8'h30};
         8'h16: r = {2'b10, 8'h31};
         8'h1E: r = {2'b10, 8'h32};
         8'h26: r = {2'b10, 8'h33};
         8'h25: r = {2'b10, 8'h34};
         8'h2E: r = {2'b10, 8'h35};
         8'h36: r = {2'b10, 8'h36};
         8'h3D: r = {2'b10, 8'h37};
         8'h3E: r = {2'b10, 8'h38};
         8'h46: r = {2'b10, 8'h39};
         8'h29: r = {2'b10, 8'h20};
         default: r = 10'h000;
      endcase
      return r;
   endfunction

   assign lookup = scan_lookup(code);
   assign busy   = (state == CLEAR);

   // State register; reset aborts any sweep in progress
   always_ff @(posedge clk) begin
      if (rst)
         state <= IDLE;
      else
         state <= next_state;
   end

   // Next-state decode: prefix bytes F0/E0 and clear requests, clear wins over a code
   always_comb begin
      next_state = state;
      case (state)
         IDLE: begin
            if (clear_req)
               next_state = CLEAR;
            else if (code_valid && code == 8'hF0)
               next_state = BRK;
            else if (code_valid && code == 8'hE0)
               next_state = EXT;
         end
         BRK: begin
            if (clear_req)
               next_state = CLEAR;
            else if (code_valid)
               next_state = IDLE;
         end
         EXT: begin
            if (clear_req)
               next_state = CLEAR;
            else if (code_valid)
               next_state = (code == 8'hF0) ? BRK : IDLE;
         end
         CLEAR: begin
            if (wr_addr == LAST_ADDR)
               next_state = IDLE;
         end
         default: next_state = IDLE;
      endcase
   end

   // Output/datapath decode: computes the next write, cursor and modifier values
   always_comb begin
      nxt_wr_en    = 1'b0;
      nxt_wr_addr  = wr_addr;
      nxt_wr_data  = wr_data;
      nxt_col      = cur_col;
      nxt_row      = cur_row;
      nxt_row_base = row_base;
      nxt_shift    = shift;
      nxt_caps     = caps;
      if (state != CLEAR && clear_req) begin
         nxt_wr_en   = 1'b1;
         nxt_wr_addr = '0;
         nxt_wr_data = BLANK_CHAR;
      end else if (state == CLEAR) begin
         if (wr_addr != LAST_ADDR) begin
            nxt_wr_en   = 1'b1;
            nxt_wr_addr = wr_addr + ONE;
            nxt_wr_data = BLANK_CHAR;
         end else begin
            nxt_col      = '0;
            nxt_row      = '0;
            nxt_row_base = '0;
         end
      end else if (code_valid && state == BRK) begin
         if (code == 8'h12 || code == 8'h59)
            nxt_shift = 1'b0;
      end else if (code_valid && state == IDLE) begin
         if (code == 8'h12 || code == 8'h59) begin
            nxt_shift = 1'b1;
         end else if (code == 8'h58) begin
            nxt_caps = ~caps;
         end else if (code == 8'h5A) begin
            nxt_col = '0;
            if (cur_row == LAST_ROW) begin
               nxt_row      = '0;
               nxt_row_base = '0;
            end else begin
               nxt_row      = cur_row + 5'd1;
               nxt_row_base = row_base + ROW_STEP;
            end
         end else if (code == 8'h66) begin
            nxt_wr_en   = 1'b1;
            nxt_wr_data = BLANK_CHAR;
            if (cur_col != 7'd0) begin
               nxt_col     = cur_col - 7'd1;
               nxt_wr_addr = row_base + ADDR_W'(cur_col) - ONE;
            end else if (cur_row != 5'd0) begin
               nxt_col      = LAST_COL;
               nxt_row      = cur_row - 5'd1;
               nxt_row_base = row_base - ROW_STEP;
               nxt_wr_addr  = row_base - ONE;
            end else begin
               nxt_wr_addr = '0;
            end
         end else if (lookup[9]) begin
            nxt_wr_en   = 1'b1;
            nxt_wr_addr = row_base + ADDR_W'(cur_col);
            nxt_wr_data = (lookup[8] && (shift ^ caps)) ? (lookup[7:0] - 8'h20) : lookup[7:0];
            if (cur_col == LAST_COL) begin
               nxt_col = '0;
               if (cur_row == LAST_ROW) begin
                  nxt_row      = '0;
                  nxt_row_base = '0;
               end else begin
                  nxt_row      = cur_row + 5'd1;
                  nxt_row_base = row_base + ROW_STEP;
               end
            end else begin
               nxt_col = cur_col + 7'd1;
            end
         end
      end
   end

   // Registers for the write port, cursor, row base and modifier flags
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_en    <= 1'b0;
         wr_addr  <= '0;
         wr_data  <= BLANK_CHAR;
         cur_col  <= '0;
         cur_row  <= '0;
         row_base <= '0;
         shift    <= 1'b0;
         caps     <= 1'b0;
      end else begin
         wr_en    <= nxt_wr_en;
         wr_addr  <= nxt_wr_addr;
         wr_data  <= nxt_wr_data;
         cur_col  <= nxt_col;
         cur_row  <= nxt_row;
         row_base <= nxt_row_base;
         shift    <= nxt_shift;
         caps     <= nxt_caps;
      end
   end

endmodule

// File: tb/tb_text_cursor_writer.sv
// Testbench for text_cursor_writer: a linear-position reference model
// predicts every RAM write into a scoreboard queue, and a monitor process
// compares each write the DUT presents against the head of that queue.
module tb_text_cursor_writer;

   localparam int         COLS   = 80;
   localparam int         ROWS   = 30;
   localparam int         ADDR_W = 12;
   localparam int         TOTAL  = COLS * ROWS;
   localparam logic [7:0] BLANK  = 8'h20;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic [7:0]        code = 8'h00;
   logic              code_valid = 1'b0;
   logic              clear_req = 1'b0;
   logic              wr_en;
   logic [ADDR_W-1:0] wr_addr;
   logic [7:0]        wr_data;
   logic [6:0]        cur_col;
   logic [4:0]        cur_row;
   logic              busy;

   int n_checks = 0;
   int n_fail   = 0;

   logic [19:0] exp_q[$];
   int          model_pos;
   bit          model_shift, model_caps, model_brk, model_ext;

   logic [7:0] letter_codes [26] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34,
                                     8'h33, 8'h43, 8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31,
                                     8'h44, 8'h4D, 8'h15, 8'h2D, 8'h1B, 8'h2C, 8'h3C,
                                     8'h2A, 8'h1D, 8'h22, 8'h35, 8'h1A};
   logic [7:0] digit_codes [10]  = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36,
                                     8'h3D, 8'h3E, 8'h46};

   text_cursor_writer #(.COLS(COLS), .ROWS(ROWS), .ADDR_W(ADDR_W), .BLANK_CHAR(BLANK)) dut (
      .clk       (clk),
      .rst       (rst),
      .code      (code),
      .code_valid(code_valid),
      .clear_req (clear_req),
      .wr_en     (wr_en),
      .wr_addr   (wr_addr),
      .wr_data   (wr_data),
      .cur_col   (cur_col),
      .cur_row   (cur_row),
      .busy      (busy)
   );

   // Free-running 100 MHz clock
   always #5 clk = ~clk;

   // Hard time limit so a stuck design still ends the run
   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation still running at %0t, required completion", $time);
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      n_checks++;
      if (actual !== expected) begin
         n_fail++;
         $display("[TB] FAIL %s: got 0x%0h, required 0x%0h", name, actual, expected);
      end
   endtask

   function automatic int printableAscii(input logic [7:0] c);
      for (int i = 0; i < 26; i++)
         if (letter_codes[i] == c)
            return ((model_shift ^ model_caps) ? 65 : 97) + i;
      for (int i = 0; i < 10; i++)
         if (digit_codes[i] == c)
            return 48 + i;
      if (c == 8'h29)
         return 32;
      return -1;
   endfunction

   task automatic pushWrite(input int addr, input int ch);
      exp_q.push_back({12'(addr), 8'(ch)});
   endtask

   task automatic modelCode(input logic [7:0] c);
      int ch;
      if (model_brk) begin
         if (c == 8'h12 || c == 8'h59)
            model_shift = 1'b0;
         model_brk = 1'b0;
      end else if (model_ext) begin
         model_brk = (c == 8'hF0);
         model_ext = 1'b0;
      end else if (c == 8'hF0) begin
         model_brk = 1'b1;
      end else if (c == 8'hE0) begin
         model_ext = 1'b1;
      end else if (c == 8'h12 || c == 8'h59) begin
         model_shift = 1'b1;
      end else if (c == 8'h58) begin
         model_caps = ~model_caps;
      end else if (c == 8'h5A) begin
         model_pos = ((model_pos / COLS + 1) % ROWS) * COLS;
      end else if (c == 8'h66) begin
         if (model_pos > 0)
            model_pos--;
         pushWrite(model_pos, BLANK);
      end else begin
         ch = printableAscii(c);
         if (ch >= 0) begin
            pushWrite(model_pos, ch);
            model_pos = (model_pos + 1) % TOTAL;
         end
      end
   endtask

   task automatic modelClear();
      for (int i = 0; i < TOTAL; i++)
         pushWrite(i, BLANK);
      model_pos = 0;
      model_brk = 1'b0;
      model_ext = 1'b0;
   endtask

   task automatic modelReset();
      exp_q.delete();
      model_pos   = 0;
      model_shift = 1'b0;
      model_caps  = 1'b0;
      model_brk   = 1'b0;
      model_ext   = 1'b0;
   endtask

   // Drives one cycle of stimulus starting at a falling edge and updates the model
   task automatic applyStimulus(input logic [7:0] c, input logic valid, input logic clr);
      code       = c;
      code_valid = valid;
      clear_req  = clr;
      if (clr)
         modelClear();
      else if (valid)
         modelCode(c);
      @(negedge clk);
      code_valid = 1'b0;
      clear_req  = 1'b0;
   endtask

   task automatic checkCursor(input string tag);
      checkOutput({tag, "_col"}, 32'(cur_col), 32'(model_pos % COLS));
      checkOutput({tag, "_row"}, 32'(cur_row), 32'(model_pos / COLS));
   endtask

   task automatic typeCode(input logic [7:0] c);
      applyStimulus(c, 1'b1, 1'b0);
      checkCursor("cursor");
   endtask

   task automatic doReset();
      modelReset();
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic runClear(input bit with_code);
      int cnt;
      applyStimulus(8'h1C, with_code, 1'b1);
      cnt = 0;
      while (busy === 1'b1 && cnt < TOTAL + 100) begin
         code       = 8'($urandom);
         code_valid = ((cnt % 97) == 5);
         clear_req  = ((cnt % 331) == 7) && (cnt < TOTAL - 10);
         @(negedge clk);
         cnt++;
      end
      code_valid = 1'b0;
      clear_req  = 1'b0;
      checkOutput("clear_busy_cycles", 32'(cnt), 32'(TOTAL));
      checkCursor("clear_cursor");
   endtask

   function automatic logic [7:0] randomCode();
      int r;
      r = $urandom_range(0, 99);
      if (r < 40) return letter_codes[$urandom_range(0, 25)];
      if (r < 55) return digit_codes[$urandom_range(0, 9)];
      if (r < 60) return 8'h29;
      if (r < 66) return 8'h12;
      if (r < 70) return 8'h59;
      if (r < 74) return 8'h58;
      if (r < 79) return 8'h5A;
      if (r < 85) return 8'h66;
      if (r < 91) return 8'hF0;
      if (r < 94) return 8'hE0;
      return 8'($urandom);
   endfunction

   // Monitor: every write the DUT presents is matched against the scoreboard head
   initial begin : monitor
      logic [19:0] exp_item;
      forever begin
         @(posedge clk);
         #1;
         if (wr_en === 1'b1) begin
            if (exp_q.size() == 0) begin
               n_checks++;
               n_fail++;
               $display("[TB] FAIL unexpected_write: got addr 0x%0h data 0x%0h, required no write",
                        wr_addr, wr_data);
            end else begin
               exp_item = exp_q.pop_front();
               checkOutput("wr_addr", 32'(wr_addr), 32'(exp_item[19:8]));
               checkOutput("wr_data", 32'(wr_data), 32'(exp_item[7:0]));
            end
         end
      end
   end

   // Main sequence: directed cases first, then randomized codes, then reset during clear
   initial begin
      modelReset();
      repeat (3) @(negedge clk);
      checkOutput("reset_wr_en", 32'(wr_en), 32'(0));
      checkOutput("reset_wr_addr", 32'(wr_addr), 32'(0));
      checkOutput("reset_wr_data", 32'(wr_data), 32'(BLANK));
      checkOutput("reset_col", 32'(cur_col), 32'(0));
      checkOutput("reset_row", 32'(cur_row), 32'(0));
      checkOutput("reset_busy", 32'(busy), 32'(0));
      rst = 1'b0;

      typeCode(8'h1C);
      typeCode(8'hF0);
      typeCode(8'h1C);
      checkOutput("tp_a_col", 32'(cur_col), 32'(1));

      doReset();
      typeCode(8'h12);
      typeCode(8'h32);
      typeCode(8'hF0);
      typeCode(8'h12);
      typeCode(8'h32);
      typeCode(8'h58);
      typeCode(8'h1C);
      checkOutput("tp_shift_col", 32'(cur_col), 32'(3));

      doReset();
      for (int i = 0; i < 79; i++)
         typeCode(8'h16);
      typeCode(8'h16);
      checkOutput("tp_eol_col", 32'(cur_col), 32'(0));
      checkOutput("tp_eol_row", 32'(cur_row), 32'(1));
      for (int i = 0; i < 28; i++)
         typeCode(8'h5A);
      for (int i = 0; i < 79; i++)
         typeCode(8'h29);
      checkOutput("tp_last_col", 32'(cur_col), 32'(79));
      checkOutput("tp_last_row", 32'(cur_row), 32'(29));
      typeCode(8'h29);
      checkOutput("tp_wrap_col", 32'(cur_col), 32'(0));
      checkOutput("tp_wrap_row", 32'(cur_row), 32'(0));

      typeCode(8'h5A);
      typeCode(8'h66);
      checkOutput("tp_bs_col", 32'(cur_col), 32'(79));
      checkOutput("tp_bs_row", 32'(cur_row), 32'(0));
      doReset();
      typeCode(8'h66);
      checkOutput("tp_bs_home_col", 32'(cur_col), 32'(0));

      for (int i = 0; i < 3; i++)
         typeCode(8'h5A);
      for (int i = 0; i < 5; i++)
         typeCode(letter_codes[i]);
      typeCode(8'h5A);
      checkOutput("tp_enter_col", 32'(cur_col), 32'(0));
      checkOutput("tp_enter_row", 32'(cur_row), 32'(4));
      typeCode(8'hE0);
      typeCode(8'h5A);
      checkOutput("tp_ext_row", 32'(cur_row), 32'(4));

      runClear(1'b1);
      typeCode(8'h1C);

      for (int i = 0; i < 800; i++) begin
         typeCode(randomCode());
         if ($urandom_range(0, 3) == 0)
            repeat ($urandom_range(1, 3)) @(negedge clk);
      end

      runClear(1'b0);
      for (int i = 0; i < 20; i++)
         typeCode(randomCode());

      applyStimulus(8'h00, 1'b0, 1'b1);
      repeat (100) @(negedge clk);
      modelReset();
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      checkOutput("midclear_rst_busy", 32'(busy), 32'(0));
      checkOutput("midclear_rst_wr_en", 32'(wr_en), 32'(0));
      checkCursor("midclear_rst_cursor");
      repeat (3) @(negedge clk);
      checkOutput("midclear_quiet_busy", 32'(busy), 32'(0));
      typeCode(8'h1C);

      repeat (5) @(negedge clk);
      checkOutput("sb_drain", 32'(exp_q.size()), 32'(0));

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/text_cursor_writer.md
Name: text_cursor_writer

Overview:
- Converts PS/2 Set-2 scan-code bytes from the keyboard receiver into character writes for the dual-port text RAM.
- The print stage reads that RAM to render the 640x480 screen.
- Tracks the cursor position, shift and caps-lock state, and handles Enter and Backspace.
- Performs a full-screen clear sweep on request.
- Sits between the keyboard block and the RAM write port.

Parameters:
- COLS, 80, characters per row (640/8)
- ROWS, 30, text rows (480/16)
- ADDR_W, 12, text RAM address width; must satisfy 2^ADDR_W >= COLS*ROWS
- BLANK_CHAR, 8'h20, code written by Backspace and by clear

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- code  in  8  scan-code byte from the keyboard receiver
- code_valid  in  1  one-cycle strobe; code is valid in that cycle
- clear_req  in  1  level or pulse; sampled every cycle; starts a screen clear
- wr_en  out  1  text RAM write enable, one-cycle pulse
- wr_addr  out  ADDR_W  write address = row*COLS + col
- wr_data  out  8  ASCII character code
- cur_col  out  7  cursor column, 0..COLS-1
- cur_row  out  5  cursor row, 0..ROWS-1
- busy  out  1  high while clearing; codes are dropped while busy

Behaviour:

Reset (synchronous, rst high at a clock edge):
- wr_en=0, wr_addr=0, wr_data=BLANK_CHAR, cur_col=0, cur_row=0, busy=0.
- shift=0, caps=0, FSM=IDLE.
- Reset mid-clear aborts the sweep immediately.

FSM states: IDLE, BRK, EXT, CLEAR.
- IDLE + code_valid:
  - code=F0 -> BRK.
  - code=E0 -> EXT.
  - Otherwise the make code is processed and the FSM stays in IDLE.
- BRK + code_valid:
  - code 12 or 59 -> shift=0.
  - Any other code is ignored.
  - Go to IDLE.
- EXT + code_valid:
  - code=F0 -> BRK.
  - Otherwise the extended make is ignored; go to IDLE.
- IDLE/BRK/EXT + clear_req -> CLEAR. clear_req has priority over a code_valid in the same cycle; that code is dropped.
- CLEAR:
  - busy=1.
  - One write per cycle: wr_en=1, wr_data=BLANK_CHAR, addresses 0..COLS*ROWS-1 ascending. Total COLS*ROWS cycles (2400 by default).
  - All code_valid pulses are ignored. clear_req has no effect.
  - After the last address: busy=0, cursor=(0,0), shift kept, IDLE.

Make-code processing (IDLE only):
- 12 or 59 -> shift=1; no write.
- 58 -> caps toggles; no write.
- 5A (Enter):
  - col=0, row=row+1. Row ROWS-1 wraps to 0 (no scroll).
  - No write.
- 66 (Backspace):
  - If col>0: col=col-1. If col=0 and row>0: col=COLS-1, row=row-1. At (0,0): no move.
  - In all three cases, write BLANK_CHAR at the new position.
- Printable:
  - Letters a-z (1C,32,21,23,24,2B,34,33,43,3B,42,4B,3A,31,44,4D,15,2D,1B,2C,3C,2A,1D,22,35,1A): uppercase when shift XOR caps, lowercase otherwise.
  - Digits 0-9 (45,16,1E,26,25,2E,36,3D,3E,46) and space (29) are unaffected by shift or caps.
  - Write the character at the cursor, then advance the cursor.
  - Advance: col+1. At col=COLS-1, col=0 and row+1. Row ROWS-1 wraps to 0.
- Any other make code: ignored, no write.

Timing:
- Latency: code_valid in cycle N -> wr_en high in cycle N+1, with wr_addr and wr_data registered.
- wr_addr uses the pre-advance position (the position the character is written to).
- cur_col/cur_row update in N+1.
- Outside CLEAR, wr_en is never high two cycles in a row for one code.
- Back-to-back code_valid pulses on consecutive cycles must be handled without loss.
- wr_addr is computed as row*COLS+col, truncated to ADDR_W; no multiplier inference is required (an incremental row-base register is allowed).

Test Plan:
- Reset, then codes 1C, F0, 1C -> one write: addr 0, data 61 ('a'); cursor (1,0); no write for the break.
- Codes 12, 32, F0, 12, 32 -> addr 0 = 42 ('B'), addr 1 = 62 ('b'); shift returns to 0 after F0 12. Repeat with 58 then 1C -> 41 ('A').
- Cursor at (79,0), code 16 -> write addr 79, data 31 ('1'), cursor (0,1). At (79,29) -> cursor wraps to (0,0).
- Cursor (0,1), code 66 -> write addr 79, data 20, cursor (79,0). At (0,0), code 66 -> write addr 0, data 20, cursor stays (0,0).
- Code 5A at (5,3) -> cursor (0,4), no wr_en. Code E0 then 5A -> ignored, cursor unchanged.
- clear_req together with code_valid=1C -> busy for 2400 cycles, addresses 0..2399 all written with 20, code dropped, cursor (0,0). Codes injected mid-clear produce no extra writes. rst asserted mid-clear -> busy=0 next cycle, wr_en=0.
